// File: rtl/circuito_exp6.sv
// Simon-style memory game ("Genius"): shows a growing ROM sequence, then checks button plays.
// Optional live echo of the buttons on leds while waiting/comparing: CIRCUITO_EXP6_ECHO_LEDS_EN.
module circuito_exp6 #(
  parameter int SHOW_CYCLES    = 500,
  parameter int GAP_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  input  logic       dificuldade,
  input  logic       memoria,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] leds,
  output logic       db_igual,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_tem_jogada,
  output logic [6:0] db_seqCont,
  output logic       db_mostra_leds
);

  localparam int CW = 16;

  typedef enum logic [3:0] {
    S_INICIAL    = 4'h0,
    S_PREP       = 4'h1,
    S_MOSTRA     = 4'h2,
    S_INTERVALO  = 4'h3,
    S_PROX_LED   = 4'h4,
    S_ESPERA     = 4'h5,
    S_REGISTRA   = 4'h6,
    S_COMPARA    = 4'h7,
    S_PROX_JOG   = 4'h8,
    S_PROX_ROD   = 4'h9,
    S_GANHOU     = 4'hA,
    S_TIMEOUT    = 4'hD,
    S_PERDEU     = 4'hE
  } state_t;

  function automatic logic [3:0] f_rom(input logic bank, input logic [3:0] addr);
    logic [3:0] v;
    if (bank) begin
      v = 4'b0001 << addr[1:0];
    end else begin
      case (addr)
        4'h0: v = 4'd1;  4'h1: v = 4'd2;  4'h2: v = 4'd4;  4'h3: v = 4'd8;
        4'h4: v = 4'd4;  4'h5: v = 4'd2;  4'h6: v = 4'd1;  4'h7: v = 4'd1;
        4'h8: v = 4'd2;  4'h9: v = 4'd2;  4'hA: v = 4'd4;  4'hB: v = 4'd4;
        4'hC: v = 4'd8;  4'hD: v = 4'd8;  4'hE: v = 4'd1;  default: v = 4'd4;
      endcase
    end
    return v;
  endfunction

  // Segments ordered g..a, active-low.
  function automatic logic [6:0] f_hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return ~s;
  endfunction

  state_t          r_state, w_next;
  logic [3:0]      r_rodada, r_addr, r_jogada;
  logic            r_mem, r_dif, r_btn_q;
  logic [CW-1:0]   r_wait, r_tout;
  logic            w_tem_jogada, w_show_done, w_gap_done, w_tout_done;
  logic            w_igual, w_fim_seq, w_ultima;
  logic [3:0]      w_rom_data;

  assign w_tem_jogada = (|botoes) & ~r_btn_q;
  assign w_rom_data   = f_rom(r_mem, r_addr);
  assign w_igual      = (r_jogada == w_rom_data);
  assign w_fim_seq    = (r_addr == r_rodada);
  assign w_ultima     = (r_rodada == (r_dif ? 4'd15 : 4'd7));
  assign w_show_done  = (r_wait == CW'(SHOW_CYCLES - 1));
  assign w_gap_done   = (r_wait == CW'(GAP_CYCLES - 1));
  assign w_tout_done  = (r_tout == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_INICIAL;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INICIAL:   if (jogar) w_next = S_PREP;
      S_PREP:      w_next = S_MOSTRA;
      S_MOSTRA:    if (w_show_done) w_next = S_INTERVALO;
      S_INTERVALO: if (w_gap_done) w_next = w_fim_seq ? S_ESPERA : S_PROX_LED;
      S_PROX_LED:  w_next = S_MOSTRA;
      S_ESPERA: begin
        if (w_tem_jogada)     w_next = S_REGISTRA;
        else if (w_tout_done) w_next = S_TIMEOUT;
      end
      S_REGISTRA:  w_next = S_COMPARA;
      S_COMPARA: begin
        if (!w_igual)                  w_next = S_PERDEU;
        else if (w_fim_seq && w_ultima) w_next = S_GANHOU;
        else if (w_fim_seq)            w_next = S_PROX_ROD;
        else                           w_next = S_PROX_JOG;
      end
      S_PROX_JOG:  w_next = S_ESPERA;
      S_PROX_ROD:  w_next = S_MOSTRA;
      S_GANHOU, S_PERDEU, S_TIMEOUT: if (jogar) w_next = S_PREP;
      default:     w_next = S_INICIAL;
    endcase
  end

  always_comb begin
    ganhou         = 1'b0;
    perdeu         = 1'b0;
    pronto         = 1'b0;
    timeout        = 1'b0;
    db_mostra_leds = 1'b0;
    leds           = 4'd0;
    case (r_state)
      S_MOSTRA: begin
        db_mostra_leds = 1'b1;
        leds           = w_rom_data;
      end
      S_INTERVALO, S_PROX_LED: db_mostra_leds = 1'b1;
`ifdef CIRCUITO_EXP6_ECHO_LEDS_EN
      S_ESPERA, S_REGISTRA, S_COMPARA: leds = botoes;
`else
      S_ESPERA, S_REGISTRA, S_COMPARA: leds = 4'd0;
`endif
      S_GANHOU: begin
        ganhou = 1'b1;
        pronto = 1'b1;
      end
      S_PERDEU: begin
        perdeu = 1'b1;
        pronto = 1'b1;
      end
      S_TIMEOUT: begin
        perdeu  = 1'b1;
        timeout = 1'b1;
        pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  // Both counters restart whenever the FSM changes state, so each phase times from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wait <= '0;
      r_tout <= '0;
    end else begin
      if (r_state != w_next)                                r_wait <= '0;
      else if (r_state == S_MOSTRA || r_state == S_INTERVALO) r_wait <= r_wait + 1'b1;
      if (r_state != w_next)         r_tout <= '0;
      else if (r_state == S_ESPERA)  r_tout <= r_tout + 1'b1;
    end
  end

  // Plays are only captured while waiting, so presses during display leave r_jogada alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rodada <= '0;
      r_addr   <= '0;
      r_jogada <= '0;
      r_mem    <= 1'b0;
      r_dif    <= 1'b0;
      r_btn_q  <= 1'b0;
    end else begin
      r_btn_q <= |botoes;
      case (r_state)
        S_PREP: begin
          r_rodada <= '0;
          r_addr   <= '0;
          r_jogada <= '0;
          r_mem    <= memoria;
          r_dif    <= dificuldade;
        end
        S_INTERVALO: if (w_gap_done && w_fim_seq) r_addr <= '0;
        S_PROX_LED, S_PROX_JOG: r_addr <= r_addr + 1'b1;
        S_ESPERA: if (w_tem_jogada) r_jogada <= botoes;
        S_PROX_ROD: begin
          r_rodada <= r_rodada + 1'b1;
          r_addr   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign db_igual       = w_igual;
  assign db_contagem    = f_hex7(r_addr);
  assign db_memoria     = f_hex7(w_rom_data);
  assign db_estado      = f_hex7(r_state);
  assign db_jogadafeita = f_hex7(r_jogada);
  assign db_seqCont     = f_hex7(r_rodada);
  assign db_clock       = clock;
  assign db_iniciar     = jogar;
  assign db_tem_jogada  = w_tem_jogada;

endmodule

// File: tb/tb_circuito_exp6.sv
// Directed bench for circuito_exp6 with shortened display/timeout parameters.
module tb_circuito_exp6;
  localparam int SHOW = 20;
  localparam int GAP  = 10;
  localparam int TO   = 100;

  localparam logic [6:0] SEG0 = 7'h40, SEG1 = 7'h79, SEG5 = 7'h12;
  localparam logic [6:0] SEGA = 7'h08, SEGD = 7'h21, SEGE = 7'h06;

  logic       clock = 1'b0;
  logic       reset, jogar, dificuldade, memoria;
  logic [3:0] botoes;
  logic       ganhou, perdeu, pronto, timeout, db_igual, db_clock, db_iniciar;
  logic       db_tem_jogada, db_mostra_leds;
  logic [3:0] leds;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_seqCont;

  int total = 0;
  int bad   = 0;

  logic [3:0] rom0 [16] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1,
                            4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd4};

  circuito_exp6 #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
    .dificuldade(dificuldade), .memoria(memoria),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .timeout(timeout),
    .leds(leds), .db_igual(db_igual), .db_contagem(db_contagem),
    .db_memoria(db_memoria), .db_estado(db_estado), .db_jogadafeita(db_jogadafeita),
    .db_clock(db_clock), .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada),
    .db_seqCont(db_seqCont), .db_mostra_leds(db_mostra_leds)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] rom_val(input logic bank, input int i);
    logic [3:0] one;
    one = 4'b0001;
    if (bank) return one << (i % 4);
    return rom0[i];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start_game(input logic mem, input logic dif);
    memoria     = mem;
    dificuldade = dif;
    jogar       = 1'b1;
    step(5);
    jogar       = 1'b0;
  endtask

  // Waits for the display phase to run and end; lands in espera_jogada.
  task automatic wait_display();
    int n;
    n = 0;
    while (db_mostra_leds !== 1'b1 && n < 3000) begin step(1); n++; end
    while (db_mostra_leds !== 1'b0 && n < 3000) begin step(1); n++; end
    check("display_end_state", db_estado, SEG5);
  endtask

  task automatic press(input logic [3:0] val, input logic exp_igual);
    botoes = val;
    #1;
    check("tem_jogada_pulse", db_tem_jogada, 1'b1);
    step(1);
    check("tem_jogada_single", db_tem_jogada, 1'b0);
    step(1);
    check("igual_at_compara", db_igual, exp_igual);
    step(8);
    botoes = 4'd0;
    step(10);
  endtask

  task automatic play_game(input logic bank, input int rounds);
    for (int r = 0; r < rounds; r++) begin
      wait_display();
      for (int i = 0; i <= r; i++) press(rom_val(bank, i), 1'b1);
    end
  endtask

  task automatic check_win(input string tag);
    check({tag, "_ganhou"}, ganhou, 1'b1);
    check({tag, "_pronto"}, pronto, 1'b1);
    check({tag, "_perdeu"}, perdeu, 1'b0);
    check({tag, "_estado"}, db_estado, SEGA);
  endtask

  initial begin
    reset = 1'b0; jogar = 1'b0; botoes = 4'd0; dificuldade = 1'b0; memoria = 1'b0;
    step(3);
    check("rst_ganhou",  ganhou, 1'b0);
    check("rst_perdeu",  perdeu, 1'b0);
    check("rst_pronto",  pronto, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_leds",    leds, 4'd0);
    check("rst_estado",  db_estado, SEG0);
    check("rst_mostra",  db_mostra_leds, 1'b0);
    check("rst_contagem", db_contagem, SEG0);
    check("rst_seqcont", db_seqCont, SEG0);
    check("rst_jogada",  db_jogadafeita, SEG0);
    check("rst_igual",   db_igual, 1'b0);
    reset = 1'b1;
    step(2);
    check("idle_estado", db_estado, SEG0);

    // Full 16-round game, bank 0
    start_game(1'b0, 1'b1);
    play_game(1'b0, 16);
    check_win("win16_b0");

    // Full 16-round game, bank 1, started from the won state
    start_game(1'b1, 1'b1);
    play_game(1'b1, 16);
    check_win("win16_b1");

    // Wrong second play in round 2
    start_game(1'b0, 1'b1);
    play_game(1'b0, 2);
    wait_display();
    press(rom0[0], 1'b1);
    press(4'b1000, 1'b0);
    check("loss_perdeu", perdeu, 1'b1);
    check("loss_pronto", pronto, 1'b1);
    check("loss_ganhou", ganhou, 1'b0);
    check("loss_timeout", timeout, 1'b0);
    check("loss_estado", db_estado, SEGE);

    // Press during display is ignored, then no play until timeout
    start_game(1'b0, 1'b1);
    check("disp_mostra", db_mostra_leds, 1'b1);
    botoes = 4'b1000;
    step(5);
    botoes = 4'd0;
    wait_display();
    check("disp_press_ignored", db_jogadafeita, SEG0);
    step(TO - 6);
    check("pre_timeout_estado", db_estado, SEG5);
    check("pre_timeout_flag", timeout, 1'b0);
    step(10);
    check("to_timeout", timeout, 1'b1);
    check("to_perdeu", perdeu, 1'b1);
    check("to_pronto", pronto, 1'b1);
    check("to_ganhou", ganhou, 1'b0);
    check("to_estado", db_estado, SEGD);

    // 8-round game, then restart
    start_game(1'b0, 1'b0);
    play_game(1'b0, 8);
    check_win("win8");
    jogar = 1'b1;
    step(1);
    check("restart_prep", db_estado, SEG1);
    jogar = 1'b0;
    step(1);
    check("restart_seqcont", db_seqCont, SEG0);
    check("restart_contagem", db_contagem, SEG0);
    check("restart_leds", leds, 4'd1);
    check("restart_pronto", pronto, 1'b0);

    // Asynchronous reset mid-display, between clock edges
    step(5);
    check("mid_mostra", db_mostra_leds, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_estado", db_estado, SEG0);
    check("async_leds", leds, 4'd0);
    check("async_mostra", db_mostra_leds, 1'b0);
    reset = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/circuito_exp6.md
Name: circuito_exp6

Overview:
- Top level of a Simon-style memory game ("Genius") for a 1 kHz board clock.
- Each round it shows a growing LED sequence read from a 16-entry ROM, then checks the player's button presses against that sequence.
- It finishes with win, loss or timeout, and exposes 7-segment debug outputs.

Parameters:
- SHOW_CYCLES, 500: cycles each LED is lit during display.
- GAP_CYCLES, 250: dark cycles between displayed LEDs.
- TIMEOUT_CYCLES, 5000: maximum cycles allowed waiting for a play.

Ports:
- clock in 1: system clock; all logic on its rising edge.
- reset in 1: asynchronous, active-low reset.
- jogar in 1: start/restart request, level-sensitive.
- botoes in 4: player buttons, one-hot when pressed.
- dificuldade in 1: 0 = 8 rounds, 1 = 16 rounds; sampled in preparacao.
- memoria in 1: ROM bank select; sampled in preparacao.
- ganhou out 1: game won.
- perdeu out 1: game lost (wrong play or timeout).
- pronto out 1: game over.
- timeout out 1: loss caused by timeout.
- leds out 4: sequence display.
- db_igual out 1: current play equals ROM data.
- db_contagem out 7: 7-segment display of the play/display address.
- db_memoria out 7: 7-segment display of the ROM data.
- db_estado out 7: 7-segment display of the state code.
- db_jogadafeita out 7: 7-segment display of the last registered play.
- db_clock out 1: copy of clock.
- db_iniciar out 1: copy of jogar.
- db_tem_jogada out 1: one-cycle pulse on button press.
- db_seqCont out 7: 7-segment display of the current round index.
- db_mostra_leds out 1: high during the entire display phase.

Behaviour:
- ROM banks, addresses 0..15, one-hot values:
  - bank 0: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4
  - bank 1: 1,2,4,8 repeated four times
- 7-segment encoder: hex digit 0..F onto segments g..a, active-low; address/round/state are 4-bit values.
- Play detection:
  - tem_jogada = rising edge of OR(botoes), using one synchronising register.
  - The pressed value is latched into the jogada register on that edge.
- Round counter r: 0..N-1, where N = 8 or 16 from dificuldade.
- Address counter a.
- Wait counter and timeout counter, each cleared on entry to its state.
- States and codes (shown on db_estado):
  - 0 inicial: entered on reset. Waits for jogar=1, then goes to 1.
  - 1 preparacao: clears r, a, jogada; latches memoria and dificuldade; goes to 2.
  - 2 mostra_led: leds = ROM[a] for SHOW_CYCLES cycles; goes to 3.
  - 3 intervalo_led: leds = 0 for GAP_CYCLES cycles. If a == r: clear a and go to 5. Otherwise go to 4.
  - 4 proximo_led: a++; goes to 2.
  - 5 espera_jogada: on tem_jogada go to 6. If TIMEOUT_CYCLES elapse without a play, go to D.
  - 6 registra: goes to 7.
  - 7 compara: on mismatch go to E. On match: a == r and r == N-1 goes to A; a == r otherwise goes to 9; else goes to 8.
  - 8 proxima_jogada: a++; goes to 5.
  - 9 proxima_rodada: r++, a = 0; goes to 2.
  - A fim_ganhou: ganhou = 1.
  - E fim_perdeu: perdeu = 1.
  - D fim_timeout: perdeu = 1 and timeout = 1.
- Final states (A, E, D): pronto = 1; jogar = 1 goes to 1.
- db_mostra_leds = 1 in states 2, 3, 4.
- Reset values: state 0, all counters 0, all scalar outputs 0, leds = 0.
- Asynchronous reset wins over any state, including mid-game.
- A press during display is ignored; no registration occurs.
- Buttons held across states produce no second pulse until released.

Optional Feature:
- Macro: CIRCUITO_EXP6_ECHO_LEDS_EN.
- Defined: in states 5, 6, 7, leds = botoes, giving live feedback of presses.
- Undefined: leds = 0 outside state 2.

Test Plan:
- Reset pulse low: all outputs 0, db_estado shows "0", leds = 0.
- memoria=0, dificuldade=1, jogar high for 5 cycles. After each fall of db_mostra_leds, play ROM[0..r], each press 10 cycles high then 10 cycles released. After round 15 the game ends: ganhou=1, pronto=1, perdeu=0, db_estado shows "A".
- Same sequence with memoria=1 (1,2,4,8 pattern) gives ganhou=1.
- memoria=0, round 2, press 4'b1000 as the second play: perdeu=1, pronto=1, db_estado shows "E".
- After display, no press for TIMEOUT_CYCLES: timeout=1, perdeu=1, pronto=1, db_estado shows "D".
- dificuldade=0, all plays correct: ganhou=1 after round 7 (8 plays). Then jogar=1 restarts into preparacao with round 0.
